mt8816_cmd_seq: RTL and testbench

// Upstream command sequencer for the MT8816 crosspoint driver. Buffers host switch commands
// (set/clear one crosspoint, or clear-all) in a FIFO and issues them one at a time on the

---
 rtl/mt8816_cmd_seq.sv | 184 ++++++++++++++++++
 tb/tb_mt8816_cmd_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mt8816_cmd_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : mt8816_cmd_seq
// Brief   : Queues host crosspoint commands and issues them one at a time to
//           the MT8816 driver, keeping a 128-bit shadow of switch states.
// Revision: 1.0 - initial release
// ============================================================================
module mt8816_cmd_seq #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     FPGA_CLK_I,
    input  logic                     RESET_N_I,
    input  logic                     CMD_VALID_I,
    output logic                     CMD_READY_O,
    input  logic                     CMD_CLR_I,
    input  logic [3:0]               CMD_AX_I,
    input  logic [2:0]               CMD_AY_I,
    input  logic                     CMD_DATA_I,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL_O,
    output logic                     BUSY_O,
    output logic                     ERR_O,
    input  logic                     ERR_CLR_I,
    input  logic [3:0]               RD_AX_I,
    input  logic [2:0]               RD_AY_I,
    output logic                     RD_STATE_O,
    output logic                     SW_EN_O,
    output logic                     SW_CLR_O,
    output logic [3:0]               SW_AX_O,
    output logic [2:0]               SW_AY_O,
    output logic                     SW_DATA_O,
    input  logic                     SW_IDLE_I
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_AW:0]   c_FULL_LEVEL = (c_AW + 1)'(DEPTH);
    localparam logic [c_TW-1:0] c_TMO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_ACK   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [8:0]        r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic [c_AW:0]     w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_timeout;
    logic              w_done;
    logic              w_tmo_hit;
    logic [8:0]        w_head;
    logic [c_TW-1:0]   r_tmo_cnt;
    logic [127:0]      r_shadow;
    logic              r_err;
    logic              r_sw_clr;
    logic [3:0]        r_sw_ax;
    logic [2:0]        r_sw_ay;
    logic              r_sw_data;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_level == c_FULL_LEVEL);
    assign w_empty   = (w_level == '0);
    assign w_push    = CMD_VALID_I && !w_full;
    assign w_head    = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_INIT:  if (SW_IDLE_I) w_state_nxt = S_ISSUE;
            S_IDLE: begin
                if (!w_empty && SW_IDLE_I) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_ACK;
            S_ACK: begin
                if (!SW_IDLE_I) begin
                    w_state_nxt = S_WAIT;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (SW_IDLE_I) begin
                    w_state_nxt = S_DONE;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge FPGA_CLK_I) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {CMD_CLR_I, CMD_AX_I, CMD_AY_I, CMD_DATA_I};
        end
    end

    always_ff @(posedge FPGA_CLK_I) begin
        if (!RESET_N_I) begin
            r_state   <= S_INIT;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_tmo_cnt <= '0;
            r_shadow  <= '0;
            r_err     <= 1'b0;
            r_sw_clr  <= 1'b1;
            r_sw_ax   <= 4'd0;
            r_sw_ay   <= 3'd0;
            r_sw_data <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                {r_sw_clr, r_sw_ax, r_sw_ay, r_sw_data} <= w_head;
            end
            // Forced clear-all after reset so the shadow matches the chip.
            if (r_state == S_INIT && SW_IDLE_I) begin
                r_sw_clr  <= 1'b1;
                r_sw_ax   <= 4'd0;
                r_sw_ay   <= 3'd0;
                r_sw_data <= 1'b0;
            end
            if (r_state == S_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_ACK || r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_done) begin
                if (r_sw_clr) begin
                    r_shadow <= '0;
                end else begin
                    r_shadow[{r_sw_ay, r_sw_ax}] <= r_sw_data;
                end
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (ERR_CLR_I) begin
                r_err <= 1'b0;
            end
        end
    end

    assign CMD_READY_O  = !w_full;
    assign FIFO_LEVEL_O = w_level;
    assign BUSY_O       = (r_state != S_IDLE) || !w_empty;
    assign ERR_O        = r_err;
    assign RD_STATE_O   = r_shadow[{RD_AY_I, RD_AX_I}];
    assign SW_EN_O      = (r_state == S_ISSUE);
    assign SW_CLR_O     = r_sw_clr;
    assign SW_AX_O      = r_sw_ax;
    assign SW_AY_O      = r_sw_ay;
    assign SW_DATA_O    = r_sw_data;

endmodule
`default_nettype wire

// File: tb/tb_mt8816_cmd_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_mt8816_cmd_seq
// Brief   : Directed bench with a driver model and a command scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mt8816_cmd_seq;

    logic       clk = 1'b0;
    logic       RESET_N_I = 1'b0;
    logic       CMD_VALID_I = 1'b0;
    logic       CMD_READY_O;
    logic       CMD_CLR_I = 1'b0;
    logic [3:0] CMD_AX_I = 4'd0;
    logic [2:0] CMD_AY_I = 3'd0;
    logic       CMD_DATA_I = 1'b0;
    logic [3:0] FIFO_LEVEL_O;
    logic       BUSY_O;
    logic       ERR_O;
    logic       ERR_CLR_I = 1'b0;
    logic [3:0] RD_AX_I = 4'd0;
    logic [2:0] RD_AY_I = 3'd0;
    logic       RD_STATE_O;
    logic       SW_EN_O;
    logic       SW_CLR_O;
    logic [3:0] SW_AX_O;
    logic [2:0] SW_AY_O;
    logic       SW_DATA_O;
    logic       sw_idle = 1'b1;

    int         vectors = 0;
    int         miscompares = 0;
    int         en_count = 0;
    int         drv_cnt = 0;
    int         drv_busy_len = 3;
    logic       drv_stall = 1'b0;
    logic       drv_respond = 1'b1;
    logic [8:0] last_cmd = 9'h100;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    mt8816_cmd_seq #(.DEPTH(8), .TIMEOUT_CYCLES(64)) dut (
        .FPGA_CLK_I  (clk),
        .RESET_N_I   (RESET_N_I),
        .CMD_VALID_I (CMD_VALID_I),
        .CMD_READY_O (CMD_READY_O),
        .CMD_CLR_I   (CMD_CLR_I),
        .CMD_AX_I    (CMD_AX_I),
        .CMD_AY_I    (CMD_AY_I),
        .CMD_DATA_I  (CMD_DATA_I),
        .FIFO_LEVEL_O(FIFO_LEVEL_O),
        .BUSY_O      (BUSY_O),
        .ERR_O       (ERR_O),
        .ERR_CLR_I   (ERR_CLR_I),
        .RD_AX_I     (RD_AX_I),
        .RD_AY_I     (RD_AY_I),
        .RD_STATE_O  (RD_STATE_O),
        .SW_EN_O     (SW_EN_O),
        .SW_CLR_O    (SW_CLR_O),
        .SW_AX_O     (SW_AX_O),
        .SW_AY_O     (SW_AY_O),
        .SW_DATA_O   (SW_DATA_O),
        .SW_IDLE_I   (sw_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver model and command monitor, both on the falling edge.
    always @(negedge clk) begin
        logic [8:0] obs;
        logic [8:0] exp;
        if (drv_stall) begin
            sw_idle = 1'b0;
        end else if (drv_cnt > 0) begin
            sw_idle = 1'b0;
            drv_cnt--;
        end else begin
            sw_idle = 1'b1;
        end
        obs = {SW_CLR_O, SW_AX_O, SW_AY_O, SW_DATA_O};
        if (!RESET_N_I) begin
            last_cmd = 9'h100;
        end else if (SW_EN_O === 1'b1) begin
            en_count++;
            chk("en_queued", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                chk("en_cmd", 32'(obs), 32'(exp));
            end
            last_cmd = obs;
            if (drv_respond) drv_cnt = drv_busy_len;
        end else begin
            chk("sw_hold", 32'(obs), 32'(last_cmd));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic clr, input logic [3:0] ax, input logic [2:0] ay, input logic d);
        int n = 0;
        while (!CMD_READY_O && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(CMD_READY_O), 32'd1);
        CMD_VALID_I = 1'b1;
        CMD_CLR_I   = clr;
        CMD_AX_I    = ax;
        CMD_AY_I    = ay;
        CMD_DATA_I  = d;
        exp_q.push_back({clr, ax, ay, d});
        tick();
        CMD_VALID_I = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (!BUSY_O) break;
            tick();
        end
        chk(tag, 32'(BUSY_O), 32'd0);
    endtask

    task automatic rd_chk(input logic [3:0] ax, input logic [2:0] ay, input logic exp, input string tag);
        RD_AX_I = ax;
        RD_AY_I = ay;
        #1;
        chk(tag, 32'(RD_STATE_O), 32'(exp));
    endtask

    initial begin
        int n0;
        exp_q.push_back(9'h100);
        repeat (3) tick();
        chk("rst_en", 32'(SW_EN_O), 32'd0);
        chk("rst_clr", 32'(SW_CLR_O), 32'd1);
        chk("rst_axaydata", 32'({SW_AX_O, SW_AY_O, SW_DATA_O}), 32'd0);
        chk("rst_level", 32'(FIFO_LEVEL_O), 32'd0);
        chk("rst_err", 32'(ERR_O), 32'd0);
        chk("rst_busy", 32'(BUSY_O), 32'd1);
        RESET_N_I = 1'b1;
        wait_idle(50, "init_idle");
        chk("init_en_count", 32'(en_count), 32'd1);

        // Single set command
        push(1'b0, 4'd3, 3'd5, 1'b1);
        wait_idle(50, "set35_idle");
        chk("set35_en_count", 32'(en_count), 32'd2);
        rd_chk(4'd3, 3'd5, 1'b1, "rd_3_5");
        rd_chk(4'd5, 3'd3, 1'b0, "rd_5_3");

        // Fill the FIFO while the driver is stalled
        drv_stall = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 4'(i + 4), 3'(i), 1'b1);
            chk("fill_level", 32'(FIFO_LEVEL_O), 32'(i + 1));
        end
        chk("full_ready", 32'(CMD_READY_O), 32'd0);
        CMD_VALID_I = 1'b1;
        CMD_CLR_I   = 1'b0;
        CMD_AX_I    = 4'd12;
        CMD_AY_I    = 3'd0;
        CMD_DATA_I  = 1'b1;
        exp_q.push_back({1'b0, 4'd12, 3'd0, 1'b1});
        repeat (3) tick();
        chk("full_hold_level", 32'(FIFO_LEVEL_O), 32'd8);
        drv_stall = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (CMD_READY_O) break;
            tick();
        end
        chk("push9_ready", 32'(CMD_READY_O), 32'd1);
        tick();
        CMD_VALID_I = 1'b0;
        wait_idle(400, "drain_idle");
        chk("drain_en_count", 32'(en_count), 32'd11);
        rd_chk(4'd11, 3'd7, 1'b1, "rd_11_7");
        rd_chk(4'd12, 3'd0, 1'b1, "rd_12_0");

        // Driver ignores EN: timeout
        drv_respond = 1'b0;
        n0 = en_count;
        push(1'b0, 4'd2, 3'd2, 1'b1);
        for (int i = 0; i < 20 && en_count == n0; i++) tick();
        chk("to_en", 32'(en_count), 32'(n0 + 1));
        repeat (63) tick();
        chk("to_err_early", 32'(ERR_O), 32'd0);
        repeat (3) tick();
        chk("to_err_set", 32'(ERR_O), 32'd1);
        rd_chk(4'd2, 3'd2, 1'b0, "to_shadow");
        drv_respond = 1'b1;
        push(1'b0, 4'd4, 3'd1, 1'b1);
        wait_idle(50, "to_next_idle");
        rd_chk(4'd4, 3'd1, 1'b1, "to_next_rd");
        chk("to_err_sticky", 32'(ERR_O), 32'd1);
        ERR_CLR_I = 1'b1;
        tick();
        ERR_CLR_I = 1'b0;
        chk("err_clr", 32'(ERR_O), 32'd0);

        // Corners then clear-all
        push(1'b0, 4'd0, 3'd0, 1'b1);
        push(1'b0, 4'd15, 3'd7, 1'b1);
        wait_idle(100, "corner_idle");
        rd_chk(4'd0, 3'd0, 1'b1, "rd_0_0_set");
        rd_chk(4'd15, 3'd7, 1'b1, "rd_15_7_set");
        push(1'b1, 4'd0, 3'd0, 1'b0);
        wait_idle(50, "clrall_idle");
        rd_chk(4'd0, 3'd0, 1'b0, "rd_0_0_clr");
        rd_chk(4'd15, 3'd7, 1'b0, "rd_15_7_clr");
        rd_chk(4'd3, 3'd5, 1'b0, "rd_3_5_clr");

        // Reset while waiting with three queued
        drv_busy_len = 1000;
        for (int i = 1; i <= 4; i++) push(1'b0, 4'(i), 3'd6, 1'b1);
        repeat (5) tick();
        chk("mid_level", 32'(FIFO_LEVEL_O), 32'd3);
        n0 = en_count;
        RESET_N_I = 1'b0;
        exp_q.delete();
        exp_q.push_back(9'h100);
        drv_busy_len = 3;
        drv_cnt = 0;
        tick();
        chk("mid_rst_level", 32'(FIFO_LEVEL_O), 32'd0);
        chk("mid_rst_en", 32'(SW_EN_O), 32'd0);
        chk("mid_rst_busy", 32'(BUSY_O), 32'd1);
        RESET_N_I = 1'b1;
        wait_idle(50, "mid_rst_idle");
        chk("mid_rst_en_count", 32'(en_count), 32'(n0 + 1));
        rd_chk(4'd1, 3'd6, 1'b0, "mid_rst_rd");
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
